// File: rtl/fht_sequencer.sv
// Run-time-length control sequencer for the in-place 4-bank FHT core: walks every butterfly
// stage and issues read, Hartley-bias, delayed write and twiddle addresses plus bank enables.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start; result bank set shown on oSOURCE_DATA
// S_READ  | 2*D read cycles of the current stage, each read index held 2 clocks
// S_DRAIN | PIPE_LAT cycles to let the butterfly write tail finish
module fht_sequencer #(
    parameter  int N_LOG2_MAX = 11,
    parameter  int PIPE_LAT   = 5,
    localparam int A_BIT      = N_LOG2_MAX - 2,
    localparam int SB         = $clog2(N_LOG2_MAX - 1)
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic [3:0]       iLEN_LOG2,
    input  logic             iABORT,
    output logic [SB-1:0]    oSTAGE,
    output logic             oST_ZERO,
    output logic             oST_LAST,
    output logic [A_BIT-1:0] oSECTOR,
    output logic             o2ND_PART_SUBSEC,
    output logic [A_BIT-1:0] oADDR_RD,
    output logic [A_BIT-1:0] oADDR_RD_BIAS,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [A_BIT-1:0] oADDR_WR_BIAS,
    output logic [A_BIT-1:0] oADDR_COEF,
    output logic             oWE_A,
    output logic             oWE_B,
    output logic             oSOURCE_DATA,
    output logic             oRDY,
    output logic             oDONE
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    localparam logic [A_BIT-1:0] ONE_A      = A_BIT'(1);
    localparam logic [3:0]       LEN_MIN    = 4'd4;
    localparam logic [3:0]       LEN_MAX    = 4'(N_LOG2_MAX);
    localparam logic [3:0]       DRAIN_LAST = 4'(PIPE_LAT - 1);

    state_t           state_q, state_d;
    logic [3:0]       len_q, len_d;
    logic [SB-1:0]    s_q, s_d;
    logic [A_BIT-1:0] r_q, r_d;
    logic             ph_q, ph_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             src_q, src_d;
    logic             done_q, done_d;
    logic             rdy_q;
    logic             flush;

    logic [3:0]       len_clamped;
    logic [A_BIT-1:0] r_last;
    logic             last_stage;

    // registered address/flag outputs, computed from next-state values
    logic [A_BIT-1:0] rd_q, rd_d, bias_q, bias_d, coef_q, coef_d, sector_q, sector_d;
    logic             half_q, half_d, stz_q, stz_d, stl_q, stl_d;
    logic             rd_act, busy_d;
    logic [SB-1:0]    dl;
    logic [A_BIT-1:0] dmask, p;

    logic [A_BIT-1:0] wr_pipe_q  [PIPE_LAT];
    logic [A_BIT-1:0] wrb_pipe_q [PIPE_LAT];
    logic [PIPE_LAT-1:0] wea_pipe_q, web_pipe_q;

    always_comb begin
        len_clamped = iLEN_LOG2;
        if (iLEN_LOG2 < LEN_MIN)      len_clamped = LEN_MIN;
        else if (iLEN_LOG2 > LEN_MAX) len_clamped = LEN_MAX;
    end

    assign r_last     = (ONE_A << (len_q - 4'd2)) - ONE_A;
    assign last_stage = (int'(s_q) == int'(len_q) - 2);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        s_d     = s_q;
        r_d     = r_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        done_d  = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (iSTART && !iABORT) begin
                    state_d = S_READ;
                    len_d   = len_clamped;
                    s_d     = '0;
                    r_d     = '0;
                    ph_d    = 1'b0;
                    src_d   = 1'b0;
                end
            end
            S_READ: begin
                if (iABORT) begin
                    state_d = S_IDLE;
                    s_d     = '0;
                    r_d     = '0;
                    ph_d    = 1'b0;
                    src_d   = 1'b0;
                    flush   = 1'b1;
                end else begin
                    ph_d = ~ph_q;
                    if (ph_q) begin
                        if (r_q == r_last) begin
                            state_d = S_DRAIN;
                            r_d     = '0;
                            cnt_d   = DRAIN_LAST;
                        end else begin
                            r_d = r_q + ONE_A;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (iABORT) begin
                    state_d = S_IDLE;
                    s_d     = '0;
                    r_d     = '0;
                    ph_d    = 1'b0;
                    src_d   = 1'b0;
                    flush   = 1'b1;
                end else if (cnt_q == '0) begin
                    // the final toggle leaves oSOURCE_DATA pointing at the result set
                    src_d = ~src_q;
                    r_d   = '0;
                    ph_d  = 1'b0;
                    if (last_stage) begin
                        state_d = S_IDLE;
                        s_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_READ;
                        s_d     = s_q + SB'(1);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // dl = log2(div); k*div is r with the low dl bits cleared, (div-p)&(div-1) is -p mod div
    always_comb begin
        rd_act   = (state_d == S_READ);
        busy_d   = (state_d != S_IDLE);
        dl       = SB'(int'(len_d) - 2 - int'(s_d));
        dmask    = (ONE_A << dl) - ONE_A;
        p        = r_d & dmask;
        rd_d     = '0;
        bias_d   = '0;
        coef_d   = '0;
        sector_d = '0;
        half_d   = 1'b0;
        if (rd_act) begin
            rd_d     = r_d;
            bias_d   = (r_d & ~dmask) | ((~p + ONE_A) & dmask);
            coef_d   = (s_d == '0) ? '0 : (p << s_d);
            sector_d = r_d >> dl;
            half_d   = (dl != '0) ? r_d[dl - SB'(1)] : 1'b0;
        end
        stz_d = busy_d && (s_d == '0);
        stl_d = busy_d && (int'(s_d) == int'(len_d) - 2);
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            s_q      <= '0;
            r_q      <= '0;
            ph_q     <= 1'b0;
            cnt_q    <= '0;
            src_q    <= 1'b0;
            done_q   <= 1'b0;
            rdy_q    <= 1'b1;
            rd_q     <= '0;
            bias_q   <= '0;
            coef_q   <= '0;
            sector_q <= '0;
            half_q   <= 1'b0;
            stz_q    <= 1'b0;
            stl_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            s_q      <= s_d;
            r_q      <= r_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            src_q    <= src_d;
            done_q   <= done_d;
            rdy_q    <= (state_d == S_IDLE);
            rd_q     <= rd_d;
            bias_q   <= bias_d;
            coef_q   <= coef_d;
            sector_q <= sector_d;
            half_q   <= half_d;
            stz_q    <= stz_d;
            stl_q    <= stl_d;
        end
    end

    // Write side: the registered read outputs delayed PIPE_LAT clocks; enables carry the
    // target set chosen at read time, so the tail always finishes inside its own stage.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                wr_pipe_q[i]  <= '0;
                wrb_pipe_q[i] <= '0;
            end
            wea_pipe_q <= '0;
            web_pipe_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                wr_pipe_q[i]  <= '0;
                wrb_pipe_q[i] <= '0;
            end
            wea_pipe_q <= '0;
            web_pipe_q <= '0;
        end else begin
            wr_pipe_q[0]  <= rd_q;
            wrb_pipe_q[0] <= bias_q;
            wea_pipe_q[0] <= (state_q == S_READ) && src_q;
            web_pipe_q[0] <= (state_q == S_READ) && !src_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                wr_pipe_q[i]  <= wr_pipe_q[i-1];
                wrb_pipe_q[i] <= wrb_pipe_q[i-1];
                wea_pipe_q[i] <= wea_pipe_q[i-1];
                web_pipe_q[i] <= web_pipe_q[i-1];
            end
        end
    end

    assign oSTAGE           = s_q;
    assign oST_ZERO         = stz_q;
    assign oST_LAST         = stl_q;
    assign oSECTOR          = sector_q;
    assign o2ND_PART_SUBSEC = half_q;
    assign oADDR_RD         = rd_q;
    assign oADDR_RD_BIAS    = bias_q;
    assign oADDR_COEF       = coef_q;
    assign oADDR_WR         = wr_pipe_q[PIPE_LAT-1];
    assign oADDR_WR_BIAS    = wrb_pipe_q[PIPE_LAT-1];
    assign oWE_A            = wea_pipe_q[PIPE_LAT-1];
    assign oWE_B            = web_pipe_q[PIPE_LAT-1];
    assign oSOURCE_DATA     = src_q;
    assign oRDY             = rdy_q;
    assign oDONE            = done_q;

endmodule

// File: tb/tb_fht_sequencer.sv
// Scoreboard bench for fht_sequencer: stimulus pushes the expected per-cycle outputs of each run,
// a monitor pops one entry for every busy or done cycle and compares.
module tb_fht_sequencer;
    localparam int NMAX = 11;
    localparam int PL   = 5;
    localparam int AB   = NMAX - 2;
    localparam int SBW  = $clog2(NMAX - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [3:0]    len = 4'd0;
    logic [SBW-1:0] o_stage;
    logic          o_stz, o_stl, o_half, o_we_a, o_we_b, o_src, o_rdy, o_done;
    logic [AB-1:0] o_sector, o_rd, o_rdb, o_wr, o_wrb, o_coef;

    fht_sequencer #(.N_LOG2_MAX(NMAX), .PIPE_LAT(PL)) dut (
        .iCLK(clk), .iRESET(rst_n), .iSTART(start), .iLEN_LOG2(len), .iABORT(abort),
        .oSTAGE(o_stage), .oST_ZERO(o_stz), .oST_LAST(o_stl), .oSECTOR(o_sector),
        .o2ND_PART_SUBSEC(o_half), .oADDR_RD(o_rd), .oADDR_RD_BIAS(o_rdb),
        .oADDR_WR(o_wr), .oADDR_WR_BIAS(o_wrb), .oADDR_COEF(o_coef),
        .oWE_A(o_we_a), .oWE_B(o_we_b), .oSOURCE_DATA(o_src), .oRDY(o_rdy), .oDONE(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rd_chk; bit wr_chk; int stage; bit stz; bit stl;
        int rd; int bias; int coef; int sector; bit half;
        bit we_a; bit we_b; int wr; int wrb; bit src; bit done;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic void addr_model(input int l, input int s, input int r,
                                       output int bias, output int coef,
                                       output int sector, output bit half);
        int d, dv, k, p;
        d  = 1 << (l - 2);
        dv = (s == 0) ? d : (d >> s);
        k  = r / dv;
        p  = r % dv;
        bias   = (k * dv + ((dv - p) % dv)) % (1 << AB);
        coef   = (s == 0) ? 0 : ((p << s) % (1 << AB));
        sector = k;
        half   = (dv >= 2) ? (p >= dv / 2) : 1'b0;
    endfunction

    // max_cycles < 0: whole run followed by the done cycle; otherwise only that many busy cycles
    task automatic push_run(input int l, input int max_cycles);
        int d, t, n, wb, wc, ws;
        bit wh;
        exp_t e;
        d = 1 << (l - 2);
        t = 2 * d + PL;
        n = 0;
        for (int s = 0; s <= l - 2; s++) begin
            for (int c = 0; c < t; c++) begin
                if (max_cycles >= 0 && n >= max_cycles) return;
                e = '{default: 0};
                e.stage = s;
                e.stz   = (s == 0);
                e.stl   = (s == l - 2);
                e.src   = ((s % 2) == 1);
                if (c < 2 * d) begin
                    e.rd_chk = 1'b1;
                    e.rd     = c / 2;
                    addr_model(l, s, c / 2, e.bias, e.coef, e.sector, e.half);
                end
                if (c >= PL && c < 2 * d + PL) begin
                    e.wr_chk = 1'b1;
                    e.we_b   = !e.src;
                    e.we_a   = e.src;
                    e.wr     = (c - PL) / 2;
                    addr_model(l, s, (c - PL) / 2, wb, wc, ws, wh);
                    e.wrb    = wb;
                end
                exp_q.push_back(e);
                n++;
            end
        end
        if (max_cycles < 0) begin
            e = '{default: 0};
            e.done = 1'b1;
            e.src  = (((l - 1) % 2) == 1);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("we_excl", int'(o_we_a & o_we_b), 0);
            if (!o_rdy || o_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", int'(o_done) * 2 + int'(!o_rdy), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdy", int'(o_rdy), int'(e.done));
                    chk("done", int'(o_done), int'(e.done));
                    chk("stage", int'(o_stage), e.stage);
                    chk("st_zero", int'(o_stz), int'(e.stz));
                    chk("st_last", int'(o_stl), int'(e.stl));
                    chk("source", int'(o_src), int'(e.src));
                    chk("we_a", int'(o_we_a), int'(e.we_a));
                    chk("we_b", int'(o_we_b), int'(e.we_b));
                    if (e.rd_chk) begin
                        chk("addr_rd", int'(o_rd), e.rd);
                        chk("addr_rd_bias", int'(o_rdb), e.bias);
                        chk("addr_coef", int'(o_coef), e.coef);
                        chk("sector", int'(o_sector), e.sector);
                        chk("2nd_part", int'(o_half), int'(e.half));
                    end
                    if (e.wr_chk) begin
                        chk("addr_wr", int'(o_wr), e.wr);
                        chk("addr_wr_bias", int'(o_wrb), e.wrb);
                    end
                end
            end
        end
    end

    function automatic int clamp_len(input int l);
        return (l < 4) ? 4 : ((l > NMAX) ? NMAX : l);
    endfunction

    task automatic run_start(input int len_in);
        push_run(clamp_len(len_in), -1);
        len   = 4'(len_in);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input string nm);
        int n = 0;
        while (n < exp_cyc + 40) begin
            @(posedge clk); #1;
            n++;
            if (o_done) break;
        end
        chk(nm, n, exp_cyc);
    endtask

    task automatic check_idle(input string nm, input int src_req);
        chk({nm, "_rdy"}, int'(o_rdy), 1);
        chk({nm, "_stage"}, int'(o_stage), 0);
        chk({nm, "_addr_rd"}, int'(o_rd), 0);
        chk({nm, "_addr_rd_bias"}, int'(o_rdb), 0);
        chk({nm, "_addr_wr"}, int'(o_wr), 0);
        chk({nm, "_we"}, int'(o_we_a | o_we_b), 0);
        chk({nm, "_done"}, int'(o_done), 0);
        chk({nm, "_source"}, int'(o_src), src_req);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset", 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // L=4, length input changed while busy must be ignored
        run_start(4);
        len = 4'd9;
        wait_done(39, "len4_cycles");
        @(posedge clk); #1;
        chk("len4_idle_source", int'(o_src), 1);

        run_start(3);
        wait_done(39, "clamp_low_cycles");
        @(posedge clk); #1;

        run_start(6);
        wait_done(185, "len6_cycles");
        @(posedge clk); #1;

        // abort during stage 1, cycle 6
        push_run(4, 20);
        len   = 4'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_idle("abort", 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", int'(o_done), 0);
        end
        chk("abort_queue", exp_q.size(), 0);

        run_start(5);
        wait_done(84, "len5_after_abort_cycles");
        @(posedge clk); #1;

        // back-to-back: start held high for the whole first run
        push_run(4, -1);
        push_run(4, -1);
        len   = 4'd4;
        start = 1'b1;
        @(posedge clk); #1;
        wait_done(39, "b2b_run1_cycles");
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accept", int'(o_rdy), 0);
        wait_done(39, "b2b_run2_cycles");
        @(posedge clk); #1;

        run_start(15);
        wait_done(10290, "clamp_high_cycles");
        @(posedge clk); #1;

        // asynchronous reset in the middle of stage 1 (source=1 at that point)
        run_start(5);
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset", 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_start(4);
        wait_done(39, "after_reset_cycles");

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
